// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmit/receive queue blocks.
//   tx_q_state_t   : launch FSM states of uart_tx_queue
//   UART_DATA_BITS : default character width
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REQ       = 2'd1,
      WAIT_DONE = 2'd2,
      RELEASE   = 2'd3
   } tx_q_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO used by the uart queue blocks.
// Ports:
//   clk, resetn        : clock, asynchronous active-low reset
//   push, wdata        : write request/data (ignored when full or flushing)
//   pop, rdata         : read request; rdata always shows the head entry
//   flush              : drops every stored entry on this edge
//   level, full, empty : registered occupancy status
module uart_sync_fifo #(
   parameter int DATA_BITS = 8,
   parameter int DEPTH     = 16
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [DATA_BITS-1:0]         wdata,
   output logic [DATA_BITS-1:0]         rdata,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         full,
   output logic                         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [DATA_BITS-1:0] mem_q [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]        level_q, level_d;
   logic                 do_push;
   logic                 do_pop;

   // flush wins over any same-cycle push or pop
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the wrap
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      level_d = level_q + 1'b1;
         else if (do_pop && !do_push) level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage carries no reset; contents are only visible through valid pointers
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign level = level_q;
   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);

endmodule

// File: rtl/uart_tx_queue.sv
// Buffered transmit front-end for the uart.
// Bytes arrive over wr_valid/wr_ready, are stored in a FIFO, and are
// launched one per frame through send_request/tx_data/parity_enable,
// paced by the uart's tx_busy/tx_done status.
// Ports:
//   clk, resetn                 : clock, asynchronous active-low reset
//   wr_valid, wr_data, wr_ready : producer interface (wr_ready = !full)
//   cfg_parity                  : parity setting, captured per byte at launch
//   flush                       : pulse, drops all not-yet-launched bytes
//   send_request, tx_data,
//   parity_enable               : registered drive to the uart
//   tx_busy, tx_done            : uart status
//   level, empty, full, idle    : queue status (level excludes in-flight byte)
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DATA_BITS = UART_DATA_BITS,
   parameter int DEPTH     = 16
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         wr_valid,
   input  logic [DATA_BITS-1:0]         wr_data,
   output logic                         wr_ready,
   input  logic                         cfg_parity,
   input  logic                         flush,
   output logic                         send_request,
   output logic [DATA_BITS-1:0]         tx_data,
   output logic                         parity_enable,
   input  logic                         tx_busy,
   input  logic                         tx_done,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         empty,
   output logic                         full,
   output logic                         idle
);

   tx_q_state_t          state_q, state_d;
   logic                 send_request_q, send_request_d;
   logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
   logic                 parity_enable_q, parity_enable_d;
   logic                 avail_q, avail_d;
   logic                 fifo_pop;
   logic [DATA_BITS-1:0] fifo_rdata;
   logic                 fifo_full;
   logic                 fifo_empty;

   uart_sync_fifo #(
      .DATA_BITS (DATA_BITS),
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (wr_valid && wr_ready),
      .pop    (fifo_pop),
      .flush  (flush),
      .wdata  (wr_data),
      .rdata  (fifo_rdata),
      .level  (level),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   always_comb begin
      state_d         = state_q;
      send_request_d  = send_request_q;
      tx_data_d       = tx_data_q;
      parity_enable_d = parity_enable_q;
      fifo_pop        = 1'b0;
      // Occupancy seen one cycle late: a byte written at edge N is launched
      // at edge N+2, and a fresh frame never starts on the RELEASE exit edge.
      avail_d         = !fifo_empty && !flush;
      case (state_q)
         IDLE: begin
            if (avail_q && !fifo_empty && !flush) begin
               fifo_pop        = 1'b1;
               tx_data_d       = fifo_rdata;
               parity_enable_d = cfg_parity;
               send_request_d  = 1'b1;
               state_d         = REQ;
            end
         end
         REQ: begin
            if (tx_busy) begin
               send_request_d = 1'b0;
               state_d        = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (tx_done) state_d = RELEASE;
         end
         RELEASE: begin
            // tx_done may be held; wait for it to fall so it is not re-used
            if (!tx_done && !tx_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q         <= IDLE;
         send_request_q  <= 1'b0;
         tx_data_q       <= '0;
         parity_enable_q <= 1'b0;
         avail_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         send_request_q  <= send_request_d;
         tx_data_q       <= tx_data_d;
         parity_enable_q <= parity_enable_d;
         avail_q         <= avail_d;
      end
   end

   assign wr_ready      = !fifo_full;
   assign full          = fifo_full;
   assign empty         = fifo_empty;
   assign send_request  = send_request_q;
   assign tx_data       = tx_data_q;
   assign parity_enable = parity_enable_q;
   assign idle          = (state_q == IDLE) && fifo_empty;

endmodule

// File: tb/tb_uart_tx_queue.sv
module tb_uart_tx_queue;

   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_ready;
   logic       cfg_parity = 1'b0;
   logic       flush = 1'b0;
   logic       send_request;
   logic [7:0] tx_data;
   logic       parity_enable;
   logic       tx_busy = 1'b0;
   logic       tx_done = 1'b0;
   logic [4:0] level;
   logic       empty;
   logic       full;
   logic       idle;

   always #5 clk = ~clk;

   uart_tx_queue #(.DATA_BITS(8), .DEPTH(16)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .wr_valid      (wr_valid),
      .wr_data       (wr_data),
      .wr_ready      (wr_ready),
      .cfg_parity    (cfg_parity),
      .flush         (flush),
      .send_request  (send_request),
      .tx_data       (tx_data),
      .parity_enable (parity_enable),
      .tx_busy       (tx_busy),
      .tx_done       (tx_done),
      .level         (level),
      .empty         (empty),
      .full          (full),
      .idle          (idle)
   );

   int   n_vec = 0;
   int   n_bad = 0;
   int   launches = 0;
   logic sr_prev = 1'b0;

   // count rising edges of send_request (one per launched byte)
   always @(negedge clk) begin
      if (send_request === 1'b1 && sr_prev !== 1'b1) launches <= launches + 1;
      sr_prev <= send_request;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       wv;
      logic [7:0] wd;
      logic       par;
      logic       fl;
      logic       busy;
      logic       done;
      logic       e_sr;
      logic [7:0] e_txd;
      logic       e_pe;
      logic [4:0] e_lvl;
      logic       e_idle;
   } vec_t;

   function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic par,
                               input logic fl, input logic busy, input logic done,
                               input logic e_sr, input logic [7:0] e_txd, input logic e_pe,
                               input logic [4:0] e_lvl, input logic e_idle);
      vec_t v;
      v.wv = wv; v.wd = wd; v.par = par; v.fl = fl; v.busy = busy; v.done = done;
      v.e_sr = e_sr; v.e_txd = e_txd; v.e_pe = e_pe; v.e_lvl = e_lvl; v.e_idle = e_idle;
      return v;
   endfunction

   task automatic push(input logic [7:0] d);
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = d;
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
   endtask

   task automatic wait_sr(input int limit);
      int t = 0;
      while (send_request !== 1'b1 && t < limit) begin
         @(negedge clk);
         t++;
      end
      chk("wait_send_request", {31'd0, send_request}, 32'd1);
   endtask

   // minimal uart stand-in: accept one request, hold tx_done for 'hold' cycles
   task automatic serve(input int hold, output logic [7:0] d, output logic p);
      @(negedge clk);
      wait_sr(60);
      d = tx_data;
      p = parity_enable;
      tx_busy = 1'b1;
      @(negedge clk);
      chk("req_drop", {31'd0, send_request}, 32'd0);
      @(negedge clk);
      tx_busy = 1'b0;
      tx_done = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("no_retrigger", {31'd0, send_request}, 32'd0);
      end
      chk("tx_data_stable", {24'd0, tx_data}, {24'd0, d});
      tx_done = 1'b0;
      @(negedge clk);
      $display("frame: data=0x%02h parity=%0d hold=%0d", d, p, hold);
   endtask

   vec_t vt[19];

   initial begin
      logic [7:0] d;
      logic       p;
      int         l0;
      int         l1;

      vt[0]  = mk(1, 8'h55, 1, 0, 0, 0,  0, 8'h00, 0, 5'd1, 0);
      vt[1]  = mk(0, 8'h00, 1, 0, 0, 0,  0, 8'h00, 0, 5'd1, 0);
      vt[2]  = mk(0, 8'h00, 1, 0, 0, 0,  1, 8'h55, 1, 5'd0, 0);
      vt[3]  = mk(0, 8'h00, 1, 0, 0, 0,  1, 8'h55, 1, 5'd0, 0);
      vt[4]  = mk(0, 8'h00, 1, 0, 1, 0,  0, 8'h55, 1, 5'd0, 0);
      vt[5]  = mk(0, 8'h00, 0, 0, 1, 0,  0, 8'h55, 1, 5'd0, 0);
      vt[6]  = mk(0, 8'h00, 0, 0, 1, 1,  0, 8'h55, 1, 5'd0, 0);
      vt[7]  = mk(0, 8'h00, 0, 0, 0, 1,  0, 8'h55, 1, 5'd0, 0);
      vt[8]  = mk(0, 8'h00, 0, 0, 0, 0,  0, 8'h55, 1, 5'd0, 1);
      vt[9]  = mk(1, 8'hA5, 0, 0, 0, 0,  0, 8'h55, 1, 5'd1, 0);
      vt[10] = mk(0, 8'h00, 0, 0, 0, 0,  0, 8'h55, 1, 5'd1, 0);
      vt[11] = mk(0, 8'h00, 0, 0, 0, 0,  1, 8'hA5, 0, 5'd0, 0);
      vt[12] = mk(0, 8'h00, 1, 0, 1, 0,  0, 8'hA5, 0, 5'd0, 0);
      vt[13] = mk(0, 8'h00, 1, 0, 0, 1,  0, 8'hA5, 0, 5'd0, 0);
      vt[14] = mk(0, 8'h00, 1, 0, 0, 0,  0, 8'hA5, 0, 5'd0, 1);
      vt[15] = mk(1, 8'h77, 1, 1, 0, 0,  0, 8'hA5, 0, 5'd0, 1);
      vt[16] = mk(1, 8'h33, 1, 0, 0, 0,  0, 8'hA5, 0, 5'd1, 0);
      vt[17] = mk(0, 8'h00, 1, 1, 0, 0,  0, 8'hA5, 0, 5'd0, 1);
      vt[18] = mk(0, 8'h00, 1, 0, 0, 0,  0, 8'hA5, 0, 5'd0, 1);

      // reset state
      #2 resetn = 1'b0;
      #1;
      chk("rst_send_request", {31'd0, send_request}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("rst_parity_enable", {31'd0, parity_enable}, 32'd0);
      chk("rst_level", {27'd0, level}, 32'd0);
      chk("rst_flags", {28'd0, empty, full, wr_ready, idle}, 32'b1011);
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      // table: single byte, per-byte parity, held status, flush with write
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         wr_valid   = vt[i].wv;
         wr_data    = vt[i].wd;
         cfg_parity = vt[i].par;
         flush      = vt[i].fl;
         tx_busy    = vt[i].busy;
         tx_done    = vt[i].done;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_send_request", i), {31'd0, send_request}, {31'd0, vt[i].e_sr});
         chk($sformatf("v%0d_tx_data", i), {24'd0, tx_data}, {24'd0, vt[i].e_txd});
         chk($sformatf("v%0d_parity_enable", i), {31'd0, parity_enable}, {31'd0, vt[i].e_pe});
         chk($sformatf("v%0d_level", i), {27'd0, level}, {27'd0, vt[i].e_lvl});
         chk($sformatf("v%0d_idle", i), {31'd0, idle}, {31'd0, vt[i].e_idle});
         $display("vec %0d: wv=%0d wd=0x%02h par=%0d fl=%0d busy=%0d done=%0d -> sr=%0d txd=0x%02h pe=%0d lvl=%0d idle=%0d",
                  i, vt[i].wv, vt[i].wd, vt[i].par, vt[i].fl, vt[i].busy, vt[i].done,
                  send_request, tx_data, parity_enable, level, idle);
      end
      @(negedge clk);
      wr_valid = 1'b0; flush = 1'b0; tx_busy = 1'b0; tx_done = 1'b0; cfg_parity = 1'b0;

      // burst fill with the uart stalled in REQ
      push(8'h00);
      wait_sr(10);
      for (int i = 1; i <= 16; i++) push(8'(i));
      #1;
      chk("burst_level", {27'd0, level}, 32'd16);
      chk("burst_full", {31'd0, full}, 32'd1);
      chk("burst_wr_ready", {31'd0, wr_ready}, 32'd0);
      chk("burst_inflight", {24'd0, tx_data}, 32'h00);
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = 8'h11;
      repeat (3) @(posedge clk);
      #1;
      chk("burst_held_off", {27'd0, level}, 32'd16);
      @(negedge clk);
      wr_valid = 1'b0;
      for (int i = 0; i <= 16; i++) begin
         serve(1, d, p);
         chk("burst_order", {24'd0, d}, i);
      end
      repeat (3) @(negedge clk);
      #1;
      chk("burst_drained_idle", {31'd0, idle}, 32'd1);

      // held tx_done: one launch per byte
      cfg_parity = 1'b1;
      l0 = launches;
      push(8'hC3);
      push(8'h3C);
      serve(10, d, p);
      chk("held_byte0", {24'd0, d}, 32'hC3);
      chk("held_par0", {31'd0, p}, 32'd1);
      serve(10, d, p);
      chk("held_byte1", {24'd0, d}, 32'h3C);
      repeat (10) @(negedge clk);
      #1;
      chk("held_launch_count", launches - l0, 32'd2);
      chk("held_idle", {31'd0, idle}, 32'd1);

      // flush while 0xAA is in WAIT_DONE
      l0 = launches;
      push(8'hAA);
      @(negedge clk);
      wait_sr(10);
      tx_busy = 1'b1;
      @(negedge clk);
      for (int i = 1; i <= 4; i++) push(8'(i));
      #1;
      chk("flush_pre_level", {27'd0, level}, 32'd4);
      @(negedge clk);
      flush    = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'hFF;
      @(posedge clk);
      #1;
      chk("flush_level", {27'd0, level}, 32'd0);
      chk("flush_empty", {31'd0, empty}, 32'd1);
      @(negedge clk);
      flush = 1'b0; wr_valid = 1'b0; tx_busy = 1'b0; tx_done = 1'b1;
      repeat (2) @(negedge clk);
      tx_done = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      chk("flush_launch_count", launches - l0, 32'd1);
      chk("flush_tx_data", {24'd0, tx_data}, 32'hAA);
      chk("flush_idle", {31'd0, idle}, 32'd1);

      // asynchronous reset during WAIT_DONE with 3 bytes queued
      push(8'hB0);
      @(negedge clk);
      wait_sr(10);
      tx_busy = 1'b1;
      @(negedge clk);
      push(8'h01); push(8'h02); push(8'h03);
      #1;
      chk("arst_pre_level", {27'd0, level}, 32'd3);
      @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("arst_send_request", {31'd0, send_request}, 32'd0);
      chk("arst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("arst_parity_enable", {31'd0, parity_enable}, 32'd0);
      chk("arst_level", {27'd0, level}, 32'd0);
      chk("arst_flags", {28'd0, empty, full, wr_ready, idle}, 32'b1011);
      tx_busy = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      l1 = launches;
      repeat (20) @(negedge clk);
      #1;
      chk("arst_no_request", launches - l1, 32'd0);
      chk("arst_idle", {31'd0, idle}, 32'd1);
      push(8'h7E);
      @(posedge clk);
      #1;
      chk("arst_new_n1", {31'd0, send_request}, 32'd0);
      @(posedge clk);
      #1;
      chk("arst_new_n2", {31'd0, send_request}, 32'd1);
      chk("arst_new_data", {24'd0, tx_data}, 32'h7E);
      serve(1, d, p);
      chk("arst_new_served", {24'd0, d}, 32'h7E);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      n_bad++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
